pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush controller for the 5-stage rv32i pipeline. Consumes the EX-stage load-use
//  bubble request, the EX branch redirect and the I/D cache handshakes. Drives per-stage register
//  load enables and holds a registered valid bit per pipeline register. Exports those valid bits
//  as active-high flush_* (flush = ~valid) to the EX-stage operand forwarding logic. Sits beside
//  the datapath and feeds that forwarding logic directly.
// PARAMETERS
//  CNT_W   32   width of each performance counter (wraps modulo 2^CNT_W)
// PORTS
//  clk           in   1      clock; all state updates on posedge
//  rst           in   1      synchronous, active-high reset
//  bubble        in   1      EX operand depends on a load in MEM (load-use)
//  br_redirect   in   1      taken branch/jump resolved in EX; meaningful only if ~flush_id_ex
//  icache_read   in   1      fetch request outstanding this cycle
//  icache_resp   in   1      fetch data valid this cycle
//  dcache_req    in   1      MEM stage has a read or write outstanding (valid instr only)
//  dcache_resp   in   1      data access completes this cycle
//  load_pc       out  1      PC register enable
//  load_if_id    out  1      IF/ID enable;  load_id_ex, load_ex_mem, load_mem_wb likewise (1 each)
//  flush_if_id   out  1      IF/ID holds a bubble;  flush_id_ex, flush_ex_mem, flush_mem_wb likewise
//  stall_cycles  out  CNT_W  cycles with any stage frozen
//  bubble_count  out  CNT_W  load-use bubbles inserted
//  flush_count   out  CNT_W  redirects taken
// BEHAVIOUR
//  Reset: all valid bits 0, so every flush_* = 1. All load_* = 0 while rst is high.
//    State = RUN. Counters = 0.
//  dstall = dcache_req & ~dcache_resp.  istall = icache_read & ~icache_resp.
//  Priority, evaluated combinationally each cycle (highest first):
//   1 dstall: every load_* = 0; no valid bit changes. stall_cycles++.
//   2 bubble: PC, IF/ID and ID/EX are held.
//       load_ex_mem = 1 with ex_mem_valid <= 0; MEM/WB advances.
//       bubble_count++, stall_cycles++. A concurrent br_redirect is ignored this cycle;
//       the branch re-resolves next cycle with forwarded data.
//   3 br_redirect & id_ex_valid: load_pc = 1 (target selected in datapath).
//       if_id_valid <= 0 and id_ex_valid <= 0; EX/MEM and MEM/WB advance; flush_count++.
//       If istall is also high, the PC still loads, and state -> SQUASH.
//   4 istall: PC and IF/ID are held. load_id_ex = 1 with id_ex_valid <= 0;
//       downstream stages advance. stall_cycles++.
//   5 otherwise: all load_* = 1; valid bits shift (id_ex <= if_id, ex_mem <= id_ex,
//       mem_wb <= ex_mem); if_id_valid <= 1.
//  FSM (2 states, enum in package):
//   RUN    -> SQUASH on a redirect that coincides with istall.
//   SQUASH: the next icache_resp is discarded, so if_id_valid <= 0 when IF/ID loads;
//     then -> RUN. dstall and bubble keep their priority in SQUASH.
//     A further redirect in SQUASH stays in SQUASH.
//  Boundary cases:
//   - dcache_resp and icache_resp in the same cycle: both stalls drop; case 5 applies.
//   - dstall overlapping an icache_resp: the fetch is frozen. The cache must hold its response
//     until load_if_id; the controller issues no re-fetch.
//   - rst mid-stall: returns to the reset state next cycle regardless of cache handshakes.
//   - Counters wrap silently; no saturation.
// STRUCTURE
//  - hazard_pkg holds the FSM enum hz_state_t {RUN, SQUASH} and the stage index
//    constants IF_ID=0..MEM_WB=3.
//  - Sub-module perf_counter (CNT_W, inc, clk, rst -> count) is instantiated three times.
//  - Valid bits live in a 4-bit register; the priority decode sits in one always_comb.
// TESTING
//  1 Reset: rst high 2 cycles -> all flush_*=1, all load_*=0, counters 0;
//    after release and 4 clean fetches -> all flush_*=0.
//  2 Load-use: bubble=1 for 1 cycle -> load_pc=load_if_id=load_id_ex=0, flush_ex_mem=1
//    next cycle, bubble_count=1.
//  3 D-miss: dcache_req=1 and dcache_resp low for 3 cycles -> all load_*=0 for 3 cycles,
//    valid bits unchanged, stall_cycles=3.
//  4 Redirect: br_redirect=1 -> next cycle flush_if_id=flush_id_ex=1, flush_count=1,
//    EX/MEM valid kept.
//  5 Redirect during I-miss: redirect with istall -> state SQUASH; the response 2 cycles later
//    loads IF/ID with flush_if_id=1; state RUN after.
//  6 bubble+br_redirect together -> flush_count stays 0, bubble_count=1;
//    redirect honoured the following cycle.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard controller:
//   hz_state_t  - controller state (RUN, SQUASH)
//   IF_ID..MEM_WB - bit positions of each pipeline register in the valid vector
// -----------------------------------------------------------------------------
package hazard_pkg;

   // RUN: normal operation. SQUASH: the next fetch response belongs to the
   // path abandoned by a redirect and must not enter IF/ID as a valid instr.
   typedef enum logic [0:0] {
      RUN    = 1'b0,
      SQUASH = 1'b1
   } hz_state_t;

   localparam int IF_ID      = 0;
   localparam int ID_EX      = 1;
   localparam int EX_MEM     = 2;
   localparam int MEM_WB     = 3;
   localparam int NUM_STAGES = 4;

endpackage

// File: rtl/pipeline_hazard_ctrl_perf_counter.sv
// -----------------------------------------------------------------------------
// perf_counter
// Free-running event counter that wraps modulo 2^CNT_W.
// Ports:
//   clk   in  clock
//   rst   in  synchronous active-high reset (count -> 0)
//   inc   in  add one this cycle
//   count out current count (registered)
// -----------------------------------------------------------------------------
module perf_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;

   // Count update; overflow wraps silently.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (inc) begin
         count_q <= count_q + CNT_W'(1);
      end else begin
         count_q <= count_q;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall/flush controller for the 5-stage rv32i pipeline. Decodes the
// data-cache stall, load-use bubble, EX redirect and instruction-cache stall
// (in that priority) into per-stage load enables, and tracks a valid bit per
// pipeline register, exported as active-high flush_* (flush = ~valid).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   bubble                   load-use hazard request from EX
//   br_redirect              taken branch/jump in EX (ignored if ID/EX invalid)
//   icache_read/icache_resp  fetch request outstanding / fetch data valid
//   dcache_req/dcache_resp   MEM access outstanding / access completes
//   load_pc, load_*          register load enables (combinational)
//   flush_*                  pipeline register holds a bubble (registered)
//   stall_cycles             cycles with any stage frozen
//   bubble_count             load-use bubbles inserted
//   flush_count              redirects taken
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bubble,
   input  logic             br_redirect,
   input  logic             icache_read,
   input  logic             icache_resp,
   input  logic             dcache_req,
   input  logic             dcache_resp,
   output logic             load_pc,
   output logic             load_if_id,
   output logic             load_id_ex,
   output logic             load_ex_mem,
   output logic             load_mem_wb,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             flush_ex_mem,
   output logic             flush_mem_wb,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] bubble_count,
   output logic [CNT_W-1:0] flush_count
);

   logic [NUM_STAGES-1:0] valid_q;
   logic [NUM_STAGES-1:0] valid_d;
   hz_state_t             state_q;
   hz_state_t             state_d;

   logic dstall_s;
   logic istall_s;
   logic stall_inc_s;
   logic bubble_inc_s;
   logic flush_inc_s;

   assign dstall_s = dcache_req & ~dcache_resp;
   assign istall_s = icache_read & ~icache_resp;

   // Priority decode of hazards into load enables, next valid bits and next state.
   always_comb begin
      valid_d      = valid_q;
      state_d      = state_q;
      load_pc      = 1'b0;
      load_if_id   = 1'b0;
      load_id_ex   = 1'b0;
      load_ex_mem  = 1'b0;
      load_mem_wb  = 1'b0;
      stall_inc_s  = 1'b0;
      bubble_inc_s = 1'b0;
      flush_inc_s  = 1'b0;

      if (rst) begin
         // Everything frozen; registers are cleared by the sequential block.
         valid_d = valid_q;
      end else if (dstall_s) begin
         // Whole pipe frozen, including any fetch response arriving now.
         stall_inc_s = 1'b1;
      end else if (bubble) begin
         // Hold the consumer in EX; a bubble enters EX/MEM. Any redirect this
         // cycle used stale operands and is re-resolved next cycle.
         load_ex_mem     = 1'b1;
         load_mem_wb     = 1'b1;
         valid_d[EX_MEM] = 1'b0;
         valid_d[MEM_WB] = valid_q[EX_MEM];
         stall_inc_s     = 1'b1;
         bubble_inc_s    = 1'b1;
      end else if (br_redirect && valid_q[ID_EX]) begin
         // Wrong-path instrs in IF/ID and ID/EX are killed; IF/ID and ID/EX
         // may load garbage since their valid bits are cleared.
         load_pc         = 1'b1;
         load_if_id      = 1'b1;
         load_id_ex      = 1'b1;
         load_ex_mem     = 1'b1;
         load_mem_wb     = 1'b1;
         valid_d[IF_ID]  = 1'b0;
         valid_d[ID_EX]  = 1'b0;
         valid_d[EX_MEM] = valid_q[ID_EX];
         valid_d[MEM_WB] = valid_q[EX_MEM];
         flush_inc_s     = 1'b1;
         // An outstanding wrong-path fetch must be discarded when it returns.
         if (istall_s) begin
            state_d = SQUASH;
         end else begin
            state_d = state_q;
         end
      end else if (istall_s) begin
         // Fetch pending: hold PC and IF/ID, drain the rest behind a bubble.
         load_id_ex      = 1'b1;
         load_ex_mem     = 1'b1;
         load_mem_wb     = 1'b1;
         valid_d[ID_EX]  = 1'b0;
         valid_d[EX_MEM] = valid_q[ID_EX];
         valid_d[MEM_WB] = valid_q[EX_MEM];
         stall_inc_s     = 1'b1;
      end else begin
         load_pc         = 1'b1;
         load_if_id      = 1'b1;
         load_id_ex      = 1'b1;
         load_ex_mem     = 1'b1;
         load_mem_wb     = 1'b1;
         valid_d[ID_EX]  = valid_q[IF_ID];
         valid_d[EX_MEM] = valid_q[ID_EX];
         valid_d[MEM_WB] = valid_q[EX_MEM];
         case (state_q)
            SQUASH: begin
               // This response is the abandoned fetch: load it as a bubble.
               valid_d[IF_ID] = 1'b0;
               state_d        = RUN;
            end
            RUN: begin
               valid_d[IF_ID] = 1'b1;
            end
            default: begin
               valid_d[IF_ID] = 1'b0;
               state_d        = RUN;
            end
         endcase
      end
   end

   // Valid-bit register and controller state.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         state_q <= RUN;
      end else begin
         valid_q <= valid_d;
         state_q <= state_d;
      end
   end

   assign flush_if_id  = ~valid_q[IF_ID];
   assign flush_id_ex  = ~valid_q[ID_EX];
   assign flush_ex_mem = ~valid_q[EX_MEM];
   assign flush_mem_wb = ~valid_q[MEM_WB];

   perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_inc_s),
      .count (stall_cycles)
   );

   perf_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (bubble_inc_s),
      .count (bubble_count)
   );

   perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush_inc_s),
      .count (flush_count)
   );

endmodule
